// File: rtl/rob_param_pkg.sv
// rob_param_pkg: shared definitions for the reorder buffer.
//   - default entry count
//   - decoded order codes (JAL, JALR, conditional branches, loads, stores)
//   - helper classifiers is_branch / is_load / is_store
// Imported by rob_order_class and rob_param.
package rob_param_pkg;

    localparam int ROB_DEPTH_DEFAULT = 16;

    // Decoded order codes. Branches, loads and stores occupy contiguous
    // ranges so the classifiers reduce to range compares.
    localparam logic [5:0] ORD_NOP   = 6'd0;
    localparam logic [5:0] ORD_LUI   = 6'd1;
    localparam logic [5:0] ORD_AUIPC = 6'd2;
    localparam logic [5:0] ORD_JAL   = 6'd3;
    localparam logic [5:0] ORD_JALR  = 6'd4;
    localparam logic [5:0] ORD_BEQ   = 6'd5;
    localparam logic [5:0] ORD_BNE   = 6'd6;
    localparam logic [5:0] ORD_BGEU  = 6'd10;
    localparam logic [5:0] ORD_LB    = 6'd11;
    localparam logic [5:0] ORD_LW    = 6'd13;
    localparam logic [5:0] ORD_LHU   = 6'd15;
    localparam logic [5:0] ORD_SB    = 6'd16;
    localparam logic [5:0] ORD_SW    = 6'd18;
    localparam logic [5:0] ORD_ADD   = 6'd19;

    function automatic logic is_branch(input logic [5:0] ord);
        return (ord >= ORD_BEQ) && (ord <= ORD_BGEU);
    endfunction

    function automatic logic is_load(input logic [5:0] ord);
        return (ord >= ORD_LB) && (ord <= ORD_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] ord);
        return (ord >= ORD_SB) && (ord <= ORD_SW);
    endfunction

endpackage

// File: rtl/rob_order_class.sv
// rob_order_class: combinational classifier of an order code.
// Ports:
//   i_order    in  6  decoded order code
//   o_is_br    out 1  conditional branch
//   o_is_jal   out 1  JAL
//   o_is_jalr  out 1  JALR
//   o_is_load  out 1  load
//   o_is_store out 1  store
module rob_order_class
    import rob_param_pkg::*;
(
    input  logic [5:0] i_order,
    output logic       o_is_br,
    output logic       o_is_jal,
    output logic       o_is_jalr,
    output logic       o_is_load,
    output logic       o_is_store
);

    assign o_is_br    = is_branch(i_order);
    assign o_is_jal   = (i_order == ORD_JAL);
    assign o_is_jalr  = (i_order == ORD_JALR);
    assign o_is_load  = is_load(i_order);
    assign o_is_store = is_store(i_order);

endmodule

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
// Circular buffer (head/tail, wrap modulo DEPTH) between issue (allocation),
// the writeback units and the commit consumers (register file, BHT, fetch).
//
// Ports:
//   clk, rst (sync, active high), rdy (global enable), clear (external flush)
//   alloc_*      allocation request from issue; alloc_ready/alloc_idx back
//   wb_*         NUM_WB writeback channels (index, value, optional target PC)
//   q1_*, q2_*   operand tag lookups
//   rf_busy/rf_tag  register-file busy state of the retiring destination
//   commit_*     retiring entry, register write and busy clear
//   head_mem_wait  head is an incomplete load/store
//   br_right/br_wrong/bht_idx  BHT update
//   redirect_pc/flush_o        mispredict redirect and self-flush
//   count        occupancy
//
// Build option: define ROB_WB_BYPASS_EN to let operand lookups also see
// writebacks arriving in the same cycle (zero-cycle wakeup).
module rob_param
    import rob_param_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH_DEFAULT,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    input  logic                   alloc_valid,
    input  logic [5:0]             alloc_order,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic [XLEN-1:0]        alloc_topc,
    input  logic [4:0]             alloc_dest,
    input  logic                   alloc_pred_jump,
    input  logic                   alloc_done,
    input  logic [XLEN-1:0]        alloc_value,
    output logic                   alloc_ready,
    output logic [IDX_W-1:0]       alloc_idx,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_idx,
    input  logic [NUM_WB*XLEN-1:0] wb_value,
    input  logic [NUM_WB-1:0]      wb_topc_vld,
    input  logic [NUM_WB*XLEN-1:0] wb_topc,
    input  logic [IDX_W-1:0]       q1_idx,
    input  logic [IDX_W-1:0]       q2_idx,
    output logic                   q1_ready,
    output logic                   q2_ready,
    output logic [XLEN-1:0]        q1_value,
    output logic [XLEN-1:0]        q2_value,
    input  logic                   rf_busy,
    input  logic [IDX_W-1:0]       rf_tag,
    output logic                   commit_reg,
    output logic                   commit_clr_busy,
    output logic [IDX_W-1:0]       commit_idx,
    output logic [4:0]             commit_dest,
    output logic [XLEN-1:0]        commit_value,
    output logic                   head_mem_wait,
    output logic                   br_right,
    output logic                   br_wrong,
    output logic [7:0]             bht_idx,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   flush_o,
    output logic [IDX_W:0]         count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    // Entry storage
    logic [5:0]      r_order     [DEPTH];
    logic [XLEN-1:0] r_pc        [DEPTH];
    logic [XLEN-1:0] r_topc      [DEPTH];
    logic [4:0]      r_dest      [DEPTH];
    logic            r_pred_jump [DEPTH];
    logic [XLEN-1:0] r_value     [DEPTH];
    logic            r_ready     [DEPTH];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    // Unpacked views of the writeback buses
    logic [IDX_W-1:0] w_wb_idx   [NUM_WB];
    logic [XLEN-1:0]  w_wb_value [NUM_WB];
    logic [XLEN-1:0]  w_wb_topc  [NUM_WB];

    for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb_unpack
        assign w_wb_idx[gi]   = wb_idx[gi*IDX_W +: IDX_W];
        assign w_wb_value[gi] = wb_value[gi*XLEN +: XLEN];
        assign w_wb_topc[gi]  = wb_topc[gi*XLEN +: XLEN];
    end

    // Head classification
    logic w_is_br, w_is_jal, w_is_jalr, w_is_load, w_is_store;

    rob_order_class u_order_class (
        .i_order    (r_order[r_head]),
        .o_is_br    (w_is_br),
        .o_is_jal   (w_is_jal),
        .o_is_jalr  (w_is_jalr),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store)
    );

    logic w_nonempty;
    logic w_head_ready;
    logic w_retire;
    logic w_accept;
    logic w_taken;
    logic w_flush_all;

    assign w_nonempty   = (r_count != '0);
    assign w_head_ready = r_ready[r_head];
    // An entry being flushed by clear in this cycle must not retire.
    assign w_retire     = rdy & ~clear & w_nonempty & w_head_ready;
    assign w_taken      = r_value[r_head][0];

    assign alloc_ready = (r_count != FULL_CNT);
    assign alloc_idx   = r_tail;
    // Full is judged before the same-cycle retire is accounted for.
    assign w_accept    = alloc_valid & alloc_ready & rdy & ~clear & ~flush_o;
    assign w_flush_all = clear | flush_o;
    assign count       = r_count;
    assign bht_idx     = r_pc[r_head][7:0];

    // Commit decode
    always_comb begin
        commit_reg  = 1'b0;
        br_right    = 1'b0;
        br_wrong    = 1'b0;
        flush_o     = 1'b0;
        redirect_pc = '0;
        if (w_retire) begin
            if (w_is_jal) begin
                commit_reg = 1'b1;
            end else if (w_is_br) begin
                if (w_taken != r_pred_jump[r_head]) begin
                    br_wrong    = 1'b1;
                    flush_o     = 1'b1;
                    redirect_pc = w_taken ? r_topc[r_head] : r_pc[r_head] + XLEN'(4);
                end else begin
                    br_right = 1'b1;
                end
            end else if (w_is_jalr) begin
                // Indirect targets are never predicted: always redirect.
                commit_reg  = 1'b1;
                flush_o     = 1'b1;
                redirect_pc = r_topc[r_head];
            end else if (!w_is_store) begin
                commit_reg = 1'b1;
            end
        end
    end

    assign commit_clr_busy = commit_reg & rf_busy & (rf_tag == r_head);
    assign commit_idx      = rdy ? r_head : '0;
    assign commit_dest     = rdy ? r_dest[r_head] : '0;
    assign commit_value    = rdy ? r_value[r_head] : '0;
    assign head_mem_wait   = rdy & w_nonempty & ~w_head_ready & (w_is_load | w_is_store);

    // Operand lookup
    always_comb begin
        q1_ready = r_ready[q1_idx];
        q1_value = r_value[q1_idx];
        q2_ready = r_ready[q2_idx];
        q2_value = r_value[q2_idx];
`ifdef ROB_WB_BYPASS_EN
        // Ascending scan so the highest matching channel wins.
        for (int c = 0; c < NUM_WB; c++) begin
            if (rdy && wb_valid[c] && (w_wb_idx[c] == q1_idx)) begin
                q1_ready = 1'b1;
                q1_value = w_wb_value[c];
            end
            if (rdy && wb_valid[c] && (w_wb_idx[c] == q2_idx)) begin
                q2_ready = 1'b1;
                q2_value = w_wb_value[c];
            end
        end
`endif
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (w_flush_all) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) r_tail <= r_tail + 1'b1;
                if (w_retire) r_head <= r_head + 1'b1;
                r_count <= r_count + (IDX_W+1)'(w_accept) - (IDX_W+1)'(w_retire);
            end
        end
    end

    // Entry storage. Later assignments win: channels ascend so the
    // highest channel wins a collision, and allocation comes last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_order[i]     <= '0;
                r_pc[i]        <= '0;
                r_topc[i]      <= '0;
                r_dest[i]      <= '0;
                r_pred_jump[i] <= 1'b0;
                r_value[i]     <= '0;
                r_ready[i]     <= 1'b0;
            end
        end else if (rdy) begin
            if (w_flush_all) begin
                // Payloads are left in place; only completion is forgotten.
                for (int i = 0; i < DEPTH; i++) r_ready[i] <= 1'b0;
            end else begin
                for (int c = 0; c < NUM_WB; c++) begin
                    if (wb_valid[c]) begin
                        r_value[w_wb_idx[c]] <= w_wb_value[c];
                        r_ready[w_wb_idx[c]] <= 1'b1;
                        if (wb_topc_vld[c]) r_topc[w_wb_idx[c]] <= w_wb_topc[c];
                    end
                end
                if (w_accept) begin
                    r_order[r_tail]     <= alloc_order;
                    r_pc[r_tail]        <= alloc_pc;
                    r_topc[r_tail]      <= alloc_topc;
                    r_dest[r_tail]      <= alloc_dest;
                    r_pred_jump[r_tail] <= alloc_pred_jump;
                    r_value[r_tail]     <= alloc_value;
                    r_ready[r_tail]     <= alloc_done;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: self-checking bench for rob_param (DEPTH=16, NUM_WB=2, XLEN=32).
// Register-write commits are predicted into a scoreboard queue at allocation
// and compared by a monitor when commit_reg is observed.
module tb_rob_param;
    import rob_param_pkg::*;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int NUM_WB = 2;
    localparam int XLEN   = 32;

    logic                    clk = 1'b0;
    logic                    rst, rdy, clear;
    logic                    alloc_valid;
    logic [5:0]              alloc_order;
    logic [XLEN-1:0]         alloc_pc, alloc_topc;
    logic [4:0]              alloc_dest;
    logic                    alloc_pred_jump, alloc_done;
    logic [XLEN-1:0]         alloc_value;
    logic                    alloc_ready;
    logic [IDX_W-1:0]        alloc_idx;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*IDX_W-1:0] wb_idx;
    logic [NUM_WB*XLEN-1:0]  wb_value;
    logic [NUM_WB-1:0]       wb_topc_vld;
    logic [NUM_WB*XLEN-1:0]  wb_topc;
    logic [IDX_W-1:0]        q1_idx, q2_idx;
    logic                    q1_ready, q2_ready;
    logic [XLEN-1:0]         q1_value, q2_value;
    logic                    rf_busy;
    logic [IDX_W-1:0]        rf_tag;
    logic                    commit_reg, commit_clr_busy;
    logic [IDX_W-1:0]        commit_idx;
    logic [4:0]              commit_dest;
    logic [XLEN-1:0]         commit_value;
    logic                    head_mem_wait, br_right, br_wrong;
    logic [7:0]              bht_idx;
    logic [XLEN-1:0]         redirect_pc;
    logic                    flush_o;
    logic [IDX_W:0]          count;

    rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alloc_valid(alloc_valid), .alloc_order(alloc_order), .alloc_pc(alloc_pc),
        .alloc_topc(alloc_topc), .alloc_dest(alloc_dest), .alloc_pred_jump(alloc_pred_jump),
        .alloc_done(alloc_done), .alloc_value(alloc_value), .alloc_ready(alloc_ready),
        .alloc_idx(alloc_idx), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .wb_topc_vld(wb_topc_vld), .wb_topc(wb_topc), .q1_idx(q1_idx), .q2_idx(q2_idx),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value),
        .rf_busy(rf_busy), .rf_tag(rf_tag), .commit_reg(commit_reg),
        .commit_clr_busy(commit_clr_busy), .commit_idx(commit_idx), .commit_dest(commit_dest),
        .commit_value(commit_value), .head_mem_wait(head_mem_wait), .br_right(br_right),
        .br_wrong(br_wrong), .bht_idx(bht_idx), .redirect_pc(redirect_pc), .flush_o(flush_o),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [4:0]       dest;
        logic [XLEN-1:0]  value;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int c, input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] val,
                          input logic tv, input logic [XLEN-1:0] tpc);
        wb_valid[c]              = 1'b1;
        wb_idx[c*IDX_W +: IDX_W] = idx;
        wb_value[c*XLEN +: XLEN] = val;
        wb_topc_vld[c]           = tv;
        wb_topc[c*XLEN +: XLEN]  = tpc;
    endtask

    task automatic clr_wb();
        wb_valid    = '0;
        wb_topc_vld = '0;
    endtask

    // Drive one allocation for a single cycle; returns the granted index.
    task automatic do_alloc(input logic [5:0] ord, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] topc, input logic [4:0] dest,
                            input logic pred, input logic done, input logic [XLEN-1:0] val,
                            output logic [IDX_W-1:0] idx);
        alloc_valid     = 1'b1;
        alloc_order     = ord;
        alloc_pc        = pc;
        alloc_topc      = topc;
        alloc_dest      = dest;
        alloc_pred_jump = pred;
        alloc_done      = done;
        alloc_value     = val;
        #1;
        idx = alloc_idx;
        tick();
        alloc_valid = 1'b0;
        $display("alloc idx=%0d order=%0d pc=0x%0h", idx, ord, pc);
    endtask

    // Commit monitor: every register-write commit must match the queue head.
    always @(negedge clk) begin
        if (!rst && commit_reg) begin
            if (sb_q.size() == 0) begin
                chk("unexp_commit", commit_reg, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("commit idx=%0d dest=%0d value=0x%0h", commit_idx, commit_dest, commit_value);
                chk("commit_idx", commit_idx, e.idx);
                chk("commit_dest", commit_dest, e.dest);
                chk("commit_value", commit_value, e.value);
                chk("commit_clr_busy", commit_clr_busy, rf_busy && (rf_tag == e.idx));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDX_W-1:0] gi_idx;
        exp_t e;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        alloc_valid = 1'b0; alloc_order = '0; alloc_pc = '0; alloc_topc = '0;
        alloc_dest = '0; alloc_pred_jump = 1'b0; alloc_done = 1'b0; alloc_value = '0;
        wb_valid = '0; wb_idx = '0; wb_value = '0; wb_topc_vld = '0; wb_topc = '0;
        q1_idx = '0; q2_idx = '0; rf_busy = 1'b0; rf_tag = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_q1_ready", q1_ready, 0);

        // Fill to capacity with incomplete ALU ops.
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc(ORD_ADD, 32'h100 + 32'(i*4), 0, 5'd1, 1'b0, 1'b0, 0, gi_idx);
            chk("fill_idx", gi_idx, i);
        end
        #1;
        chk("full_count", count, DEPTH);
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_tail_wrap", alloc_idx, 0);
        alloc_valid = 1'b1; alloc_order = ORD_ADD;
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("full_ignore_count", count, DEPTH);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("clear_count", count, 0);
        chk("clear_alloc_ready", alloc_ready, 1);

        // In-order commit after out-of-order writeback.
        rf_busy = 1'b1; rf_tag = 4'd0;
        for (int i = 0; i < 3; i++) begin
            do_alloc(ORD_ADD, 32'h400 + 32'(i*4), 0, 5'(i+1), 1'b0, 1'b0, 0, gi_idx);
            chk("alu_idx", gi_idx, i);
            e.idx = gi_idx; e.dest = 5'(i+1); e.value = 32'h100 + 32'(i*'h11);
            sb_q.push_back(e);
        end
        set_wb(0, 4'd1, 32'h111, 1'b0, 0);
        tick(); clr_wb(); #1;
        chk("ooo_no_commit", commit_reg, 0);
        set_wb(0, 4'd0, 32'h100, 1'b0, 0);
        tick(); clr_wb(); #1;
        chk("ooo_commit0_reg", commit_reg, 1);
        chk("ooo_commit0_idx", commit_idx, 0);
        chk("ooo_commit0_clr", commit_clr_busy, 1);
        tick(); #1;
        chk("ooo_commit1_reg", commit_reg, 1);
        chk("ooo_commit1_idx", commit_idx, 1);
        chk("ooo_commit1_clr", commit_clr_busy, 0);
        tick(); #1;
        chk("ooo_idx2_wait", commit_reg, 0);
        chk("ooo_count1", count, 1);
        set_wb(1, 4'd2, 32'h122, 1'b0, 0);
        tick(); clr_wb(); #1;
        chk("ooo_commit2_idx", commit_idx, 2);
        tick(); #1;
        chk("ooo_empty", count, 0);
        rf_busy = 1'b0;

        // Mispredicted conditional branch flushes everything behind it.
        do_alloc(ORD_BEQ, 32'h1000, 32'h1004, 5'd0, 1'b0, 1'b0, 0, gi_idx);
        do_alloc(ORD_ADD, 32'h1004, 0, 5'd4, 1'b0, 1'b0, 0, e.idx);
        #1;
        chk("br_count2", count, 2);
        set_wb(0, gi_idx, 32'h1, 1'b1, 32'h1040);
        tick(); clr_wb(); #1;
        chk("br_wrong", br_wrong, 1);
        chk("br_flush", flush_o, 1);
        chk("br_redirect", redirect_pc, 32'h1040);
        chk("br_wrong_no_right", br_right, 0);
        chk("br_bht_idx", bht_idx, 8'h00);
        tick(); #1;
        chk("br_flush_count", count, 0);
        chk("br_flush_deassert", flush_o, 0);

        // Correctly predicted taken branch.
        do_alloc(ORD_BNE, 32'h1010, 32'h2000, 5'd0, 1'b1, 1'b0, 0, gi_idx);
        set_wb(1, gi_idx, 32'h1, 1'b1, 32'h2000);
        tick(); clr_wb(); #1;
        chk("br_right", br_right, 1);
        chk("br_right_no_wrong", br_wrong, 0);
        chk("br_right_no_flush", flush_o, 0);
        chk("br_right_bht_idx", bht_idx, 8'h10);
        tick(); #1;
        chk("br_right_count", count, 0);

        // JALR always redirects to its resolved target.
        do_alloc(ORD_JALR, 32'h200, 32'h0, 5'd1, 1'b0, 1'b0, 0, gi_idx);
        e.idx = gi_idx; e.dest = 5'd1; e.value = 32'h204;
        sb_q.push_back(e);
        set_wb(0, gi_idx, 32'h204, 1'b1, 32'h300);
        tick(); clr_wb(); #1;
        chk("jalr_commit_reg", commit_reg, 1);
        chk("jalr_flush", flush_o, 1);
        chk("jalr_redirect", redirect_pc, 32'h300);
        tick(); #1;
        chk("jalr_count", count, 0);

        // Writeback collisions.
        for (int i = 0; i < 6; i++) begin
            do_alloc(ORD_ADD, 32'h600, 0, 5'd2, 1'b0, 1'b0, 0, gi_idx);
        end
        alloc_valid = 1'b1; alloc_order = ORD_ADD; alloc_done = 1'b0; alloc_value = 0;
        set_wb(1, 4'd6, 32'h77, 1'b0, 0);
        tick(); alloc_valid = 1'b0; clr_wb(); q2_idx = 4'd6; #1;
        chk("alloc_beats_wb", q2_ready, 0);
        set_wb(0, 4'd5, 32'hA, 1'b0, 0);
        set_wb(1, 4'd5, 32'hB, 1'b0, 0);
        q1_idx = 4'd5;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("bypass_q1_ready", q1_ready, 1);
        chk("bypass_q1_value", q1_value, 32'hB);
`else
        chk("nobypass_q1_ready", q1_ready, 0);
`endif
        tick(); clr_wb(); #1;
        chk("wb_collide_ready", q1_ready, 1);
        chk("wb_collide_value", q1_value, 32'hB);
        chk("wb_collide_no_commit", commit_reg, 0);
        clear = 1'b1;
        tick(); clear = 1'b0; #1;
        chk("collide_clear_count", count, 0);

        // Stall with a ready head, then clear.
        do_alloc(ORD_ADD, 32'h700, 0, 5'd7, 1'b0, 1'b1, 32'h55, gi_idx);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_no_commit", commit_reg, 0);
            chk("stall_count", count, 1);
            tick();
        end
        rdy = 1'b1; clear = 1'b1;
        #1;
        chk("clear_no_commit", commit_reg, 0);
        tick(); clear = 1'b0; q1_idx = 4'd0; #1;
        chk("stall_clear_count", count, 0);
        chk("stall_clear_ready", q1_ready, 0);

        // Incomplete load at head, then a store that retires silently.
        do_alloc(ORD_LW, 32'h800, 0, 5'd9, 1'b0, 1'b0, 0, gi_idx);
        #1;
        chk("mem_wait", head_mem_wait, 1);
        e.idx = gi_idx; e.dest = 5'd9; e.value = 32'hDEAD;
        sb_q.push_back(e);
        set_wb(1, gi_idx, 32'hDEAD, 1'b0, 0);
        tick(); clr_wb(); #1;
        chk("mem_wait_clear", head_mem_wait, 0);
        chk("load_commit", commit_reg, 1);
        tick();
        do_alloc(ORD_SW, 32'h804, 0, 5'd0, 1'b0, 1'b1, 0, gi_idx);
        #1;
        chk("store_no_reg", commit_reg, 0);
        chk("store_count", count, 1);
        tick(); #1;
        chk("store_retired", count, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the out-of-order core.
- Sits between the issue queue (allocation), the reservation stations and load/store buffer (writeback), and the register file, BHT and fetch (commit).
- Generalises the fixed 16-entry, two-writeback ROB with:
  - configurable depth and writeback channel count;
  - a real full/backpressure handshake;
  - self-flush on mispredict;
  - an optional same-cycle writeback bypass for operand lookup.

Parameters:
- DEPTH, 16: entry count; power of two, ≥4.
- IDX_W, $clog2(DEPTH): entry index width.
- NUM_WB, 2: writeback channels (channel 0 = RS, 1 = SLB, extras = further units).
- XLEN, 32: data/PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state.
- clear  in  1  external flush.
- alloc_valid  in  1  issue requests entry.
- alloc_order  in  6  decoded order code.
- alloc_pc, alloc_topc  in  XLEN  instruction PC, predicted target.
- alloc_dest  in  5  destination register.
- alloc_pred_jump  in  1  predicted taken.
- alloc_done  in  1  entry complete at allocation (e.g. LUI).
- alloc_value  in  XLEN  value if alloc_done.
- alloc_ready  out  1  not full.
- alloc_idx  out  IDX_W  tail index granted.
- wb_valid  in  NUM_WB  per-channel writeback strobe.
- wb_idx  in  NUM_WB*IDX_W  target entries.
- wb_value  in  NUM_WB*XLEN  results; for conditional branches bit0 = taken.
- wb_topc_vld  in  NUM_WB  overwrite target PC.
- wb_topc  in  NUM_WB*XLEN  resolved target.
- q1_idx, q2_idx  in  IDX_W  operand tags.
- q1_ready, q2_ready  out  1  tag resolved.
- q1_value, q2_value  out  XLEN  tag value.
- rf_busy  in  1  busy bit of commit_dest in register file.
- rf_tag  in  IDX_W  its tag.
- commit_reg  out  1  write register file.
- commit_clr_busy  out  1  also clear busy.
- commit_idx  out  IDX_W  retiring entry.
- commit_dest  out  5.
- commit_value  out  XLEN  also broadcast to RS/SLB when commit_reg.
- head_mem_wait  out  1  head is an incomplete load/store (SLB may execute).
- br_right, br_wrong  out  1  BHT update pulses.
- bht_idx  out  8  inst PC bits [7:0].
- redirect_pc  out  XLEN.
- flush_o  out  1  mispredict flush.
- count  out  IDX_W+1  occupancy.

Behaviour:
- **Storage:** circular buffer with head and tail pointers, width IDX_W, wrap modulo DEPTH. Count is IDX_W+1 bits.
- **Reset or clear** (clear has priority over all but rst, and acts only when rdy):
  - head=tail=0, count=0, all ready bits 0.
  - Entry payloads are unchanged on clear; reset zeroes them.
- **rdy=0:** no state changes. All pulse outputs (commit_*, br_*, flush_o, head_mem_wait) are forced 0.
- **Allocation:**
  - alloc_ready = (count != DEPTH); alloc_idx = tail.
  - Accepted when alloc_valid & alloc_ready & rdy & !clear & !flush_o.
  - On accept, the entry is written with ready=alloc_done, and tail++.
  - Full is judged on the pre-commit count; no alloc when full even if the head commits the same cycle.
- **Writeback:**
  - Each wb_valid sets value and ready of its entry at the clock edge; wb_topc_vld also updates topc.
  - Same-index collision: the higher channel wins.
  - Writeback in the same cycle as allocation to that index: allocation wins.
- **Commit:** at most one per cycle, combinational from head. Requires count≠0 and head ready; retiring means head++.
  - JAL: commit_reg=1.
  - Conditional branch: if taken != pred_jump, assert br_wrong, flush_o, and redirect_pc = taken ? topc : pc+4. Otherwise assert br_right.
  - JALR: always br_wrong-style redirect to topc with flush_o, and commit_reg=1.
  - Store: retire only; no register write.
  - Other including load: commit_reg=1.
  - commit_clr_busy = commit_reg & rf_busy & (rf_tag==head).
  - Head not ready and load/store: head_mem_wait=1.
- **Mispredict self-flush:** flush_o asserted ⇒ at the next edge the buffer empties as for clear. No allocation or commit bookkeeping beyond that.
- **count update:** count_next = count + alloc_accept − retire.
- **Lookup:** q*_ready and q*_value read stored state combinationally.
- **Commit latency:** an entry completed at edge N may retire in cycle N+1.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined: q*_ready/q*_value also match same-cycle wb_valid channels on the queried index (highest matching channel wins), giving zero-cycle operand wakeup.
- Undefined: lookups see registered state only (one-cycle later wakeup).

Decomposition:
- Shared package holds:
  - order code constants (JAL, JALR, branch codes, load/store ranges);
  - helper functions is_branch, is_load, is_store;
  - the DEPTH default.
- One natural sub-module: rob_order_class, a combinational classifier of the head order code into branch/jal/jalr/load/store flags.

Test Plan:
- Fill DEPTH=16 with 16 allocs, no writeback → alloc_ready=0 after 16th, count=16, 17th request ignored, tail wraps to 0.
- Alloc 3 ALU ops to idx 0..2, writeback idx1 then idx0 → commit order idx0 then idx1 on consecutive cycles, commit_value matches, commit_clr_busy=1 when rf_tag=0 and rf_busy=1.
- Conditional branch pred_jump=0, wb value bit0=1, topc=0x1040 → br_wrong, flush_o, redirect_pc=0x1040, next cycle count=0. Same with matching prediction → br_right only.
- JALR at head, pc=0x200, topc=0x300 → commit_reg=1, flush_o=1, redirect_pc=0x300.
- Both channels write idx 5 in one cycle with values 0xA and 0xB → stored 0xB. With ROB_WB_BYPASS_EN, q1_idx=5 shows ready/0xB in that cycle; without it, from the next cycle.
- rdy low for 3 cycles with ready head, then clear with rdy=1 → no commit during stall, then empty.
